// File: rtl/bram_stream_pkg.sv
// ---------------------------------------------------------------------------
// bram_stream_pkg
// Shared definitions for the BRAM-to-stream burst reader:
//   - state_e             : reader FSM states (IDLE / ISSUE / DRAIN)
//   - RL_LOW_LATENCY      : READ_LATENCY value for a BRAM without output register
//   - RL_HIGH_PERFORMANCE : READ_LATENCY value for a BRAM with output register
// ---------------------------------------------------------------------------
package bram_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // waiting for start
    ST_ISSUE = 2'd1,  // issuing reads, subject to buffer credit
    ST_DRAIN = 2'd2   // all reads issued, emptying the return buffer
  } state_e;

  localparam int RL_LOW_LATENCY      = 1;
  localparam int RL_HIGH_PERFORMANCE = 2;

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with first-word fall-through read data.
// DEPTH must be a power of two; pointers carry one extra wrap bit so that
// full and empty are distinguishable without a separate flag.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset (clears pointers)
//   push       : write push_data this cycle
//   push_data  : WIDTH-bit write word
//   pop        : consume the head word this cycle
//   pop_data   : head word (valid while !empty)
//   full       : DEPTH words stored
//   empty      : no words stored
//   count      : current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  // A pop on a full FIFO frees the slot being written, so push is still legal.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone
  // define which entries are meaningful, and leaving it unreset lets it map
  // onto distributed RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign pop_data = mem[rd_ptr[AW-1:0]];
  assign count    = wr_ptr - rd_ptr;
  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/bram_stream_reader.sv
// ---------------------------------------------------------------------------
// bram_stream_reader
// Reads a burst of len consecutive words from a BRAM port starting at
// base_addr and presents them as a valid/ready stream with a last marker.
// Reads are credit-limited so the return buffer can absorb every word that
// is in flight even while the consumer stalls.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   start      : one-cycle burst request (accepted only when idle)
//   base_addr  : first BRAM address, sampled with start
//   len        : burst length in words, sampled with start (0 = empty burst)
//   busy       : burst in progress
//   done       : one-cycle completion pulse
//   mem_en     : BRAM enable, one read per cycle it is high
//   mem_addr   : BRAM read address
//   mem_regce  : BRAM output-register enable
//   mem_dout   : BRAM read data
//   m_valid    : stream beat valid
//   m_ready    : stream consumer ready
//   m_data     : stream beat data
//   m_last     : final beat of the burst
// ---------------------------------------------------------------------------
module bram_stream_reader
  import bram_stream_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 9,
  parameter int LEN_WIDTH    = 10,
  parameter int READ_LATENCY = RL_HIGH_PERFORMANCE,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_regce,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e                  state;
  logic [ADDR_WIDTH-1:0]   addr_q;      // next address once the burst is running
  logic [LEN_WIDTH-1:0]    issue_left;  // reads still to issue while in ISSUE
  logic [LEN_WIDTH-1:0]    len_q;
  logic [LEN_WIDTH-1:0]    push_cnt;    // words returned so far in this burst
  logic [READ_LATENCY-1:0] vld;         // vld[i]: a read issued i+1 cycles ago

  logic                    accept;
  logic                    zero_start;
  logic                    credit_ok;
  logic                    push;
  logic                    push_last;
  logic                    pop;
  logic                    last_pop;
  logic [CW-1:0]           inflight;
  logic [CW-1:0]           fifo_count;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [DATA_WIDTH:0]     fifo_out;

  assign accept     = (state == ST_IDLE) && start && (len != '0);
  assign zero_start = (state == ST_IDLE) && start && (len == '0);

  // NOTE: every always_comb output gets a default before any conditional
  // update, so no path can leave it unassigned and infer a latch.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + CW'(vld[i]);
  end

  // Reads in the BRAM pipeline plus words already buffered must leave room
  // for one more, otherwise a stalled consumer could overflow the buffer.
  assign credit_ok = !fifo_full &&
                     (({1'b0, inflight} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH));

  // The first read goes out in the start cycle itself (the buffer is always
  // empty when idle), which saves a cycle of latency.
  assign mem_en   = accept || ((state == ST_ISSUE) && credit_ok);
  assign mem_addr = accept ? base_addr : addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      addr_q     <= '0;
      issue_left <= '0;
      len_q      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            addr_q     <= base_addr + 1'b1;
            issue_left <= len - 1'b1;
            len_q      <= len;
            state      <= (len == LEN_WIDTH'(1)) ? ST_DRAIN : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (mem_en) begin
            addr_q     <= addr_q + 1'b1;
            issue_left <= issue_left - 1'b1;
            if (issue_left == LEN_WIDTH'(1)) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (last_pop) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Read-return tracking: the word for a read appears on mem_dout exactly
  // READ_LATENCY cycles after its mem_en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld      <= '0;
      push_cnt <= '0;
    end else begin
      vld[0] <= mem_en;
      for (int i = 1; i < READ_LATENCY; i++) vld[i] <= vld[i-1];
      if (accept)    push_cnt <= '0;
      else if (push) push_cnt <= push_cnt + 1'b1;
    end
  end

  assign push      = vld[READ_LATENCY-1];
  assign push_last = (push_cnt == len_q - 1'b1);

  generate
    if (READ_LATENCY == RL_HIGH_PERFORMANCE) begin : g_regce_pipe
      assign mem_regce = vld[0];
    end else begin : g_regce_tied
      // No output register to steer; held high outside of reset.
      assign mem_regce = !rst;
    end
  endgenerate

  // Data and last marker travel together through the buffer.
  sync_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({push_last, mem_dout}),
    .pop       (pop),
    .pop_data  (fifo_out),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign m_valid  = !fifo_empty;
  assign pop      = m_valid && m_ready;
  assign last_pop = pop && fifo_out[DATA_WIDTH];

  // Gate the unreset buffer contents so the stream reads zero when idle.
  assign m_data = fifo_empty ? '0 : fifo_out[DATA_WIDTH-1:0];
  assign m_last = !fifo_empty && fifo_out[DATA_WIDTH];

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) done <= 1'b0;
    else     done <= zero_start || last_pop;
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_bram_stream_reader
// Two readers (READ_LATENCY = 1 and 2) share one stimulus stream. Each is
// attached to its own BRAM model over a common memory image. The expected
// response of a burst is derived directly from its definition: beat i
// carries mem[(base + i) mod 512], the last beat carries m_last, done pulses
// once, and issued-minus-consumed words never exceed the buffer depth.
// ---------------------------------------------------------------------------
module tb_bram_stream_reader;

  localparam int DW    = 32;
  localparam int AW    = 9;
  localparam int LW    = 10;
  localparam int DEPTH = 4;
  localparam int MAXB  = 64;

  typedef struct {
    logic [AW-1:0] base;
    logic [LW-1:0] len;
    int            mode;       // 0 ready high, 1 ready low in cycles 3..10, 2 random
    int            restart;    // cycle of a second start pulse, -1 for none
    int            exp_beats;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] len;
  logic          m_ready;

  logic          busy_a      [2];
  logic          done_a      [2];
  logic          mem_en_a    [2];
  logic          mem_regce_a [2];
  logic          m_valid_a   [2];
  logic          m_last_a    [2];
  logic [AW-1:0] mem_addr_a  [2];
  logic [DW-1:0] mem_dout_a  [2];
  logic [DW-1:0] m_data_a    [2];

  logic [DW-1:0] mem [512];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_inst
    logic [DW-1:0] s1;
    logic [DW-1:0] s2;
    always @(posedge clk) begin
      if (mem_en_a[k])    s1 <= mem[mem_addr_a[k]];
      if (mem_regce_a[k]) s2 <= s1;
    end
    assign mem_dout_a[k] = (k == 0) ? s1 : s2;

    bram_stream_reader #(
      .DATA_WIDTH   (DW),
      .ADDR_WIDTH   (AW),
      .LEN_WIDTH    (LW),
      .READ_LATENCY (k + 1),
      .FIFO_DEPTH   (DEPTH)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .len       (len),
      .busy      (busy_a[k]),
      .done      (done_a[k]),
      .mem_en    (mem_en_a[k]),
      .mem_addr  (mem_addr_a[k]),
      .mem_regce (mem_regce_a[k]),
      .mem_dout  (mem_dout_a[k]),
      .m_valid   (m_valid_a[k]),
      .m_ready   (m_ready),
      .m_data    (m_data_a[k]),
      .m_last    (m_last_a[k])
    );
  end

  // ---------------- monitor (samples on the falling edge) ----------------
  int            cyc = 0;
  int            burst_id = 0;
  int            seen_id = 0;
  int            addr_n   [2];
  int            cap_n    [2];
  int            done_cnt [2];
  int            done_cyc [2];
  int            busy_cnt [2];
  int            busy_bad [2];
  int            hold_bad [2];
  int            outst    [2];
  int            max_out  [2];
  int            start_cyc[2];
  logic          prev_hold[2];
  logic [DW:0]   prev_word[2];
  logic [AW-1:0] addr_log [2][MAXB];
  logic [DW:0]   cap      [2][MAXB];
  int            cap_cyc  [2][MAXB];

  always @(negedge clk) begin
    cyc = cyc + 1;
    for (int k = 0; k < 2; k++) begin
      if (seen_id != burst_id) begin
        addr_n[k] = 0; cap_n[k] = 0; done_cnt[k] = 0; done_cyc[k] = -1;
        busy_cnt[k] = 0; busy_bad[k] = 0; hold_bad[k] = 0; outst[k] = 0;
        max_out[k] = 0; start_cyc[k] = -1; prev_hold[k] = 1'b0;
      end
      if (!rst) begin
        if (start && !busy_a[k] && start_cyc[k] < 0) start_cyc[k] = cyc;
        if (mem_en_a[k]) begin
          if (addr_n[k] < MAXB) addr_log[k][addr_n[k]] = mem_addr_a[k];
          addr_n[k]++;
          outst[k]++;
        end
        if (m_valid_a[k] && m_ready) begin
          if (cap_n[k] < MAXB) begin
            cap[k][cap_n[k]]     = {m_last_a[k], m_data_a[k]};
            cap_cyc[k][cap_n[k]] = cyc;
          end
          cap_n[k]++;
          outst[k]--;
        end
        if (outst[k] > max_out[k]) max_out[k] = outst[k];
        if (done_a[k]) begin
          done_cnt[k]++;
          done_cyc[k] = cyc;
          if (busy_a[k]) busy_bad[k]++;
        end
        if (busy_a[k]) busy_cnt[k]++;
        if (prev_hold[k] &&
            (!m_valid_a[k] || {m_last_a[k], m_data_a[k]} != prev_word[k]))
          hold_bad[k]++;
        prev_hold[k] = m_valid_a[k] && !m_ready;
        prev_word[k] = {m_last_a[k], m_data_a[k]};
      end
    end
    seen_id = burst_id;
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic fill_mem(input bit rnd);
    for (int a = 0; a < 512; a++) mem[a] = rnd ? DW'($urandom) : DW'(a);
  endtask

  function automatic logic ready_for(input int mode, input int r);
    case (mode)
      0:       return 1'b1;
      1:       return !(r >= 3 && r <= 10);
      default: return ($urandom_range(0, 3) != 0);
    endcase
  endfunction

  task automatic check_idle_outputs(input string tag, input bit in_reset);
    for (int k = 0; k < 2; k++) begin
      string t = $sformatf("%s rl%0d", tag, k + 1);
      check({t, " busy"},      busy_a[k],      0);
      check({t, " done"},      done_a[k],      0);
      check({t, " mem_en"},    mem_en_a[k],    0);
      check({t, " mem_addr"},  mem_addr_a[k],  0);
      check({t, " m_valid"},   m_valid_a[k],   0);
      check({t, " m_last"},    m_last_a[k],    0);
      check({t, " m_data"},    m_data_a[k],    0);
      check({t, " mem_regce"}, mem_regce_a[k], (!in_reset && k == 0) ? 1 : 0);
    end
  endtask

  task automatic run_burst(input logic [AW-1:0] b, input logic [LW-1:0] l,
                           input int mode, input int restart);
    int tail = 0;
    bit fin  = 1'b0;
    @(posedge clk); #1;
    burst_id++;
    start = 1'b1; base_addr = b; len = l; m_ready = ready_for(mode, 0);
    for (int r = 1; r < 600 && !fin; r++) begin
      @(posedge clk); #1;
      start     = (r == restart);
      base_addr = AW'($urandom);
      len       = (r == restart) ? LW'(3) : LW'($urandom);
      m_ready   = ready_for(mode, r);
      if (done_cnt[0] > 0 && done_cnt[1] > 0) tail++;
      if (tail >= 6) fin = 1'b1;
    end
    start = 1'b0;
    check("burst_timeout", fin, 1);
  endtask

  task automatic check_burst(input logic [AW-1:0] b, input logic [LW-1:0] l,
                             input int mode, input int exp_beats);
    for (int k = 0; k < 2; k++) begin
      int    rl = k + 1;
      string t  = $sformatf("rl%0d b%0h l%0d", rl, b, l);
      int    n  = (int'(l) < MAXB) ? int'(l) : MAXB;
      int    gap_bad = 0;
      check({t, " beats"}, cap_n[k],  exp_beats);
      check({t, " reads"}, addr_n[k], exp_beats);
      for (int i = 0; i < n; i++) begin
        logic [AW-1:0] ea = b + i[AW-1:0];
        if (i < addr_n[k]) check($sformatf("%s addr%0d", t, i), addr_log[k][i], ea);
        if (i < cap_n[k])
          check($sformatf("%s beat%0d", t, i), cap[k][i], {(i == int'(l) - 1), mem[ea]});
      end
      check({t, " done_pulses"},  done_cnt[k], 1);
      check({t, " busy_at_done"}, busy_bad[k], 0);
      check({t, " busy_seen"},    (busy_cnt[k] != 0), (l != 0));
      check({t, " over_depth"},   (max_out[k] > DEPTH), 0);
      check({t, " hold_stable"},  hold_bad[k], 0);
      if (mode == 0 && l != 0 && cap_n[k] == int'(l) && int'(l) <= MAXB) begin
        for (int i = 1; i < n; i++) if (cap_cyc[k][i] != cap_cyc[k][0] + i) gap_bad++;
        check({t, " latency"},     cap_cyc[k][0] - start_cyc[k], rl + 1);
        check({t, " back2back"},   gap_bad, 0);
        check({t, " done_timing"}, done_cyc[k] - cap_cyc[k][n-1], 1);
      end
    end
  endtask

  // ---------------- test sequence ----------------
  vec_t tbl [7];

  initial begin
    tbl[0] = '{base: 9'h010, len: 10'd4,  mode: 0, restart: -1, exp_beats: 4};
    tbl[1] = '{base: 9'h1FE, len: 10'd4,  mode: 0, restart: -1, exp_beats: 4};
    tbl[2] = '{base: 9'h000, len: 10'd0,  mode: 0, restart: -1, exp_beats: 0};
    tbl[3] = '{base: 9'h0A0, len: 10'd8,  mode: 1, restart: -1, exp_beats: 8};
    tbl[4] = '{base: 9'h040, len: 10'd6,  mode: 0, restart: 2,  exp_beats: 6};
    tbl[5] = '{base: 9'h1F0, len: 10'd1,  mode: 0, restart: -1, exp_beats: 1};
    tbl[6] = '{base: 9'h123, len: 10'd12, mode: 2, restart: -1, exp_beats: 12};

    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; m_ready = 1'b1;
    fill_mem(1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("in_reset", 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("after_reset", 1'b0);

    // Directed table: data equals address so beats are easy to read.
    for (int v = 0; v < 7; v++) begin
      run_burst(tbl[v].base, tbl[v].len, tbl[v].mode, tbl[v].restart);
      check_burst(tbl[v].base, tbl[v].len, tbl[v].mode, tbl[v].exp_beats);
    end

    // Reset in the middle of a 6-beat burst, then a fresh 2-beat burst.
    begin
      bit got2 = 1'b0;
      @(posedge clk); #1;
      burst_id++;
      start = 1'b1; base_addr = 9'h080; len = 10'd6; m_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int r = 0; r < 50 && !got2; r++) begin
        if (cap_n[0] >= 2 && cap_n[1] >= 2) got2 = 1'b1;
        else begin @(posedge clk); #1; end
      end
      check("midreset_wait", got2, 1);
      rst = 1'b1;
      #1;
      check_idle_outputs("midreset", 1'b1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      burst_id++;
      repeat (5) @(posedge clk);
      #1;
      check("post_reset beats rl1", cap_n[0], 0);
      check("post_reset beats rl2", cap_n[1], 0);
      check("post_reset reads rl1", addr_n[0], 0);
      check("post_reset reads rl2", addr_n[1], 0);
      run_burst(9'h0C0, 10'd2, 0, -1);
      check_burst(9'h0C0, 10'd2, 0, 2);
    end

    // Randomized bursts over random memory contents and random backpressure.
    for (int n = 0; n < 8; n++) begin
      logic [AW-1:0] rb = AW'($urandom);
      logic [LW-1:0] rl = LW'($urandom_range(0, 20));
      fill_mem(1'b1);
      run_burst(rb, rl, 2, -1);
      check_burst(rb, rl, 2, int'(rl));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
